// File: rtl/linear_wgrad_batch.sv
// linear_wgrad_batch: batched weight gradient dW[m][n] = sum_b g[b][m]*x[b][n] with saturation.
// Each tensor is reached through a request/done handle; only one handle is ever active at a time.
module linear_wgrad_batch #(
  parameter int DATA_W    = 32,
  parameter int FRAC_BITS = 0,
  parameter int ACC_W     = 2*DATA_W+16,
  parameter int DIM_W     = 16,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic [ADDR_W-1:0] x_base,
  output logic              x_r_en,
  output logic              x_avail,
  output logic [ADDR_W-1:0] x_ptr,
  input  logic [DATA_W-1:0] x_data_load,
  input  logic              x_done,
  input  logic [ADDR_W-1:0] g_base,
  output logic              g_r_en,
  output logic              g_avail,
  output logic [ADDR_W-1:0] g_ptr,
  input  logic [DATA_W-1:0] g_data_load,
  input  logic              g_done,
  input  logic [ADDR_W-1:0] w_base,
  output logic              w_r_en,
  output logic              w_w_en,
  output logic              w_avail,
  output logic [ADDR_W-1:0] w_ptr,
  output logic [DATA_W-1:0] w_data_store,
  input  logic [DATA_W-1:0] w_data_load,
  input  logic              w_done,
  input  logic              go,
  input  logic              acc_mode,
  output logic              done,
  output logic              err,
  output logic              busy
);
  typedef enum logic [3:0] {IDLE, HDR_X, HDR_G, CHECK, HDR_W, ELEM, LD_G, LD_X, MAC, LD_W, WR_W, DONE, ERR} state_t;
  state_t state, nxt;
  logic act, acc_mode_r, bad;
  logic [1:0] k;
  logic [DIM_W-1:0] bx, m_dim, n_dim, b, m, n;
  logic [ADDR_W-1:0] x_off, g_off, w_off, addr, off;
  logic signed [DATA_W-1:0] gv, xv;
  logic signed [ACC_W-1:0] acc;
  logic signed [2*DATA_W-1:0] prod, sh;
  logic [ACC_W-DATA_W:0] hi;
  logic [DATA_W-1:0] sat, hdr_word, wdata, rdata;
  logic sx, sg, sw, hdr, wr, fin, ovf, tail_w, last;
  assign sx = state inside {HDR_X, LD_X};
  assign sg = state inside {HDR_G, LD_G};
  assign sw = state inside {HDR_W, LD_W, WR_W};
  assign hdr = state inside {HDR_X, HDR_G, HDR_W};
  assign wr = (state == WR_W) || (state == HDR_W && !acc_mode_r);
  assign off = hdr ? ADDR_W'(k) : ADDR_W'(3) + (sx ? x_off : sg ? g_off : w_off);
  assign addr = (sx ? x_base : sg ? g_base : w_base) + off;
  assign fin = act && (sx ? x_done : sg ? g_done : sw && w_done);
  assign rdata = sx ? x_data_load : sg ? g_data_load : w_data_load;
  assign hdr_word = k == 2'd0 ? DATA_W'(2) : k == 2'd1 ? DATA_W'(m_dim) : DATA_W'(n_dim);
  assign prod = gv * xv;
  assign sh = prod >>> FRAC_BITS;
  assign hi = acc[ACC_W-1:DATA_W-1];
  assign ovf = !((&hi) || !(|hi));
  assign sat = ovf ? {acc[ACC_W-1], {(DATA_W-1){!acc[ACC_W-1]}}} : acc[DATA_W-1:0];
  assign wdata = state == WR_W ? sat : hdr_word;
  assign tail_w = acc_mode_r;
  assign last = (m == m_dim - DIM_W'(1)) && (n == n_dim - DIM_W'(1));
  assign x_r_en = act && sx;
  assign x_avail = act && sx;
  assign x_ptr = act && sx ? addr : '0;
  assign g_r_en = act && sg;
  assign g_avail = act && sg;
  assign g_ptr = act && sg ? addr : '0;
  assign w_r_en = act && sw && !wr;
  assign w_w_en = act && sw && wr;
  assign w_avail = act && sw;
  assign w_ptr = act && sw ? addr : '0;
  assign w_data_store = act && sw && wr ? wdata : '0;
  assign done = state inside {DONE, ERR};
  assign err = state == ERR;
  assign busy = !(state inside {IDLE, DONE, ERR});
  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = go ? HDR_X : IDLE;
      HDR_X: nxt = fin && k == 2'd2 ? HDR_G : HDR_X;
      HDR_G: nxt = fin && k == 2'd2 ? CHECK : HDR_G;
      CHECK: nxt = bad ? ERR : HDR_W;
      HDR_W: if (fin) nxt = acc_mode_r && rdata != hdr_word ? ERR :
                            k != 2'd2 ? HDR_W : (m_dim != '0 && n_dim != '0) ? ELEM : DONE;
      ELEM:  nxt = bx != '0 ? LD_G : tail_w ? LD_W : WR_W;
      LD_G:  nxt = fin ? LD_X : LD_G;
      LD_X:  nxt = fin ? MAC : LD_X;
      MAC:   nxt = (b + DIM_W'(1)) < bx ? LD_G : tail_w ? LD_W : WR_W;
      LD_W:  nxt = fin ? WR_W : LD_W;
      WR_W:  nxt = !fin ? WR_W : last ? DONE : ELEM;
      DONE:  nxt = go ? DONE : IDLE;
      ERR:   nxt = go ? ERR : IDLE;
      default: nxt = IDLE;
    endcase
  end
  // A request stays up until its done is sampled; the gap cycle that follows keeps one access per handle.
  always_ff @(posedge clk or negedge rst_l)
    if (!rst_l) begin
      act <= 1'b0; acc_mode_r <= 1'b0; bad <= 1'b0; k <= '0;
      bx <= '0; m_dim <= '0; n_dim <= '0; b <= '0; m <= '0; n <= '0;
      x_off <= '0; g_off <= '0; w_off <= '0; gv <= '0; xv <= '0; acc <= '0;
    end else begin
      act <= (sx || sg || sw) && !fin;
      if (fin && hdr) k <= k == 2'd2 ? 2'd0 : k + 2'd1;
      case (state)
        IDLE: if (go) begin acc_mode_r <= acc_mode; k <= '0; bad <= 1'b0; end
        HDR_X: if (fin) begin
          if (k == 2'd0) bad <= bad || rdata != DATA_W'(2);
          if (k == 2'd1) bx <= rdata[DIM_W-1:0];
          if (k == 2'd2) n_dim <= rdata[DIM_W-1:0];
        end
        HDR_G: if (fin) begin
          if (k == 2'd0) bad <= bad || rdata != DATA_W'(2);
          if (k == 2'd1) bad <= bad || rdata != DATA_W'(bx);
          if (k == 2'd2) m_dim <= rdata[DIM_W-1:0];
        end
        CHECK: begin m <= '0; n <= '0; w_off <= '0; end
        ELEM: begin acc <= '0; b <= '0; g_off <= ADDR_W'(m); x_off <= ADDR_W'(n); end
        LD_G: if (fin) gv <= rdata;
        LD_X: if (fin) xv <= rdata;
        MAC: begin
          acc <= acc + {{(ACC_W-2*DATA_W){sh[2*DATA_W-1]}}, sh};
          b <= b + DIM_W'(1);
          g_off <= g_off + ADDR_W'(m_dim);
          x_off <= x_off + ADDR_W'(n_dim);
        end
        LD_W: if (fin) acc <= acc + {{(ACC_W-DATA_W){rdata[DATA_W-1]}}, rdata};
        WR_W: if (fin) begin
          w_off <= w_off + ADDR_W'(1);
          n <= n == n_dim - DIM_W'(1) ? '0 : n + DIM_W'(1);
          if (n == n_dim - DIM_W'(1)) m <= m + DIM_W'(1);
        end
        default: ;
      endcase
    end
endmodule
